// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer that steps a 3-8 decoder through the channels enabled in a mask.
// Each channel is held for a programmable dwell, and the sequencer runs either one frame or continuously.
//
// state | meaning
// IDLE  | no scan active, outputs parked at 0, waiting for an enabled Start_In
// SCAN  | holding the active channel for its dwell, then advancing through the mask
module decoder_scan_sequencer #(
    parameter int DWELL_WIDTH = 8
) (
    input  logic                   Clock_In,
    input  logic                   Reset_In,
    input  logic                   Start_In,
    input  logic                   Enable_In,
    input  logic                   Single_Shot_In,
    input  logic [7:0]             Channel_Mask_In,
    input  logic [DWELL_WIDTH-1:0] Dwell_In,
    output logic [2:0]             Encoded_Value_Out,
    output logic                   Valid_Out,
    output logic                   Busy_Out,
    output logic                   Channel_Advance_Out,
    output logic                   Frame_Done_Out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic [2:0]             r_chan;
    logic [DWELL_WIDTH-1:0] r_cnt;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_adv;
    logic                   r_done;

    logic [2:0] w_first;
    logic [2:0] w_next;
    logic [2:0] w_idx;
    logic       w_found;
    logic       w_wrap;
    logic       w_mask_any;

    // The search runs upward from r_chan+1. The final probe (offset 8) lands back on
    // r_chan itself, which is how a mask with a single bit wraps onto that same channel.
    always_comb begin
        w_next  = r_chan;
        w_found = 1'b0;
        w_idx   = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            w_idx = r_chan + 3'(k);
            if (!w_found && Channel_Mask_In[w_idx]) begin
                w_next  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_first = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (Channel_Mask_In[i]) begin
                w_first = 3'(i);
            end
        end
    end

    assign w_mask_any = |Channel_Mask_In;
    assign w_wrap     = (w_next <= r_chan);

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            r_state <= ST_IDLE;
            r_chan  <= 3'd0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_adv   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_adv  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start_In && Enable_In && w_mask_any) begin
                        r_state <= ST_SCAN;
                        r_chan  <= w_first;
                        r_cnt   <= Dwell_In;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (Enable_In) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - DWELL_ONE;
                        end else if (!w_mask_any) begin
                            r_state <= ST_IDLE;
                            r_chan  <= 3'd0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                        end else if (w_wrap && Single_Shot_In) begin
                            r_state <= ST_IDLE;
                            r_chan  <= 3'd0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_chan <= w_next;
                            r_cnt  <= Dwell_In;
                            r_adv  <= 1'b1;
                            r_done <= w_wrap;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Encoded_Value_Out   = r_chan;
    assign Valid_Out           = r_valid;
    assign Busy_Out            = r_busy;
    assign Channel_Advance_Out = r_adv;
    assign Frame_Done_Out      = r_done;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench for decoder_scan_sequencer. A behavioural scan model queues the
// expected outputs for each edge, and an independent monitor pops and compares them.
module tb_decoder_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic       single = 1'b0;
    logic [7:0] mask = 8'h00;
    logic [7:0] dwell = 8'h00;

    logic [2:0] enc;
    logic       valid;
    logic       busy;
    logic       adv;
    logic       done;

    always #5 clk = ~clk;

    decoder_scan_sequencer #(.DWELL_WIDTH(8)) dut (
        .Clock_In            (clk),
        .Reset_In            (rst),
        .Start_In            (start),
        .Enable_In           (en),
        .Single_Shot_In      (single),
        .Channel_Mask_In     (mask),
        .Dwell_In            (dwell),
        .Encoded_Value_Out   (enc),
        .Valid_Out           (valid),
        .Busy_Out            (busy),
        .Channel_Advance_Out (adv),
        .Frame_Done_Out      (done)
    );

    // Expected outputs packed as {enc[2:0], valid, busy, advance, frame_done}.
    logic [6:0] exp_q[$];
    logic [6:0] mon_exp;
    logic [6:0] mon_act;
    int         n_checks = 0;
    int         n_pass   = 0;

    // Reference model state: whether a scan is running, which channel is active,
    // and how many enabled cycles remain on that channel after the current one.
    bit m_active = 1'b0;
    int m_chan   = 0;
    int m_left   = 0;

    task automatic step(input bit r, input bit s, input bit e, input bit sg,
                        input logic [7:0] mk, input logic [7:0] dw);
        logic [6:0] ex;
        int         nxt;
        bit         wrapped;
        @(negedge clk);
        rst = r; start = s; en = e; single = sg; mask = mk; dwell = dw;
        ex = 7'd0;
        if (r) begin
            m_active = 1'b0;
            m_chan   = 0;
        end else if (!m_active) begin
            if (s && e && mk != 8'h00) begin
                m_chan = 0;
                while (!mk[m_chan]) m_chan++;
                m_left   = int'(dw);
                m_active = 1'b1;
                ex = {3'(m_chan), 4'b1100};
            end
        end else if (!e || m_left > 0) begin
            if (e) m_left--;
            ex = {3'(m_chan), 4'b1100};
        end else if (mk == 8'h00) begin
            m_active = 1'b0;
            m_chan   = 0;
        end else begin
            nxt = -1;
            for (int k = 1; k <= 8; k++)
                if (nxt < 0 && mk[(m_chan + k) % 8]) nxt = (m_chan + k) % 8;
            wrapped = (nxt <= m_chan);
            if (wrapped && sg) begin
                m_active = 1'b0;
                m_chan   = 0;
                ex = 7'b000_0001;
            end else begin
                m_chan = nxt;
                m_left = int'(dw);
                ex = {3'(m_chan), 3'b111, wrapped};
            end
        end
        exp_q.push_back(ex);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {enc, valid, busy, adv, done};
            n_checks++;
            if (mon_act === mon_exp) n_pass++;
            else $display("FAIL outputs t=%0t got enc=%0d v=%0b b=%0b adv=%0b fd=%0b want enc=%0d v=%0b b=%0b adv=%0b fd=%0b",
                          $time, mon_act[6:4], mon_act[3], mon_act[2], mon_act[1], mon_act[0],
                          mon_exp[6:4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
        end
    end

    initial begin
        logic [7:0] rmask;
        logic [7:0] rdw;
        bit         rsg;
        int         seg_len;

        // Reset state.
        repeat (3) step(1, 0, 1, 0, 8'hA6, 8'd2);

        // Starts that must be ignored: Enable_In low, empty mask, no Start_In.
        step(0, 1, 0, 0, 8'hA6, 8'd2);
        step(0, 1, 1, 0, 8'h00, 8'd2);
        step(0, 0, 1, 0, 8'hA6, 8'd2);

        // Continuous frame over channels 1,2,5,7 with Start_In held high while scanning,
        // then a reset together with Start_In while channel 5 is active.
        step(0, 1, 1, 0, 8'hA6, 8'd2);
        repeat (30) step(0, 1, 1, 0, 8'hA6, 8'd2);
        step(1, 1, 1, 0, 8'hA6, 8'd2);
        step(0, 0, 1, 0, 8'hA6, 8'd2);

        // Single shot across all channels with a one-cycle dwell.
        step(0, 1, 1, 1, 8'hFF, 8'd0);
        repeat (11) step(0, 0, 1, 1, 8'hFF, 8'd0);

        // Single channel wrapping onto itself.
        step(0, 1, 1, 0, 8'h10, 8'd1);
        repeat (9) step(0, 0, 1, 0, 8'h10, 8'd1);
        step(1, 0, 1, 0, 8'h10, 8'd1);

        // Freeze in the middle of the channel-2 dwell.
        step(0, 1, 1, 0, 8'hA6, 8'd7);
        repeat (10) step(0, 0, 1, 0, 8'hA6, 8'd7);
        repeat (5) step(0, 0, 0, 0, 8'hA6, 8'd7);
        repeat (12) step(0, 0, 1, 0, 8'hA6, 8'd7);
        step(1, 0, 1, 0, 8'hA6, 8'd7);

        // Mask edits: clear the active channel's bit mid-dwell, then empty the mask.
        step(0, 1, 1, 0, 8'hA6, 8'd3);
        repeat (5) step(0, 0, 1, 0, 8'hA4, 8'd3);
        repeat (6) step(0, 0, 1, 0, 8'h00, 8'd3);

        // Randomized segments.
        for (int seg = 0; seg < 60; seg++) begin
            rmask   = ($urandom_range(7, 0) == 0) ? 8'h00 : 8'($urandom);
            rdw     = 8'($urandom_range(3, 0));
            rsg     = bit'($urandom_range(1, 0));
            seg_len = $urandom_range(20, 4);
            for (int c = 0; c < seg_len; c++)
                step(($urandom_range(40, 0) == 0), ($urandom_range(3, 0) == 0),
                     ($urandom_range(9, 0) != 0), rsg, rmask, rdw);
        end

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending expectations want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
